// File: rtl/mvm_pkg.sv
// Shared types and sizing helpers for the UART matrix-vector multiply engine.
package mvm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_K,
        ST_LOAD_X,
        ST_COMPUTE,
        ST_SEND
    } state_t;

    localparam logic [7:0] OP_LOAD_K = 8'h01;
    localparam logic [7:0] OP_LOAD_X = 8'h02;

    // Exact width of a C-term dot product of W_X by W_K operands.
    function automatic int unsigned acc_width(input int unsigned w_x, input int unsigned w_k,
                                              input int unsigned c);
        return w_x + w_k + int'($clog2(c));
    endfunction

    function automatic int unsigned bytes_per_y(input int unsigned w_y);
        return (w_y + 7) / 8;
    endfunction

    // Counter width able to index n entries, never below one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? int'($clog2(n)) : 1;
    endfunction

endpackage

// File: rtl/mvm_stream_engine_if.sv
// Byte-stream and status bundle between the UART pair and the MVM engine.
interface mvm_stream_engine_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       k_loaded;
    logic       busy;
    logic       err;

    modport master (
        output s_data, s_valid, m_ready,
        input  s_ready, m_data, m_valid, k_loaded, busy, err
    );

    modport slave (
        input  s_data, s_valid, m_ready,
        output s_ready, m_data, m_valid, k_loaded, busy, err
    );
endinterface

// File: rtl/mvm_mac.sv
// Single multiply-accumulate: extends operands per SIGNED, exact W_ACC accumulator.
module mvm_mac #(
    parameter int unsigned W_X    = 4,
    parameter int unsigned W_K    = 4,
    parameter int unsigned W_ACC  = 9,
    parameter bit          SIGNED = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic [W_X-1:0]   x,
    input  logic [W_K-1:0]   k,
    output logic [W_ACC-1:0] sum_c
);

    logic [W_ACC-1:0] acc;
    logic [W_ACC-1:0] x_ext;
    logic [W_ACC-1:0] k_ext;
    logic [W_ACC-1:0] prod;

    // Modular W_ACC arithmetic is exact for both signednesses at this width.
    always_comb begin
        if (SIGNED) begin
            x_ext = W_ACC'($signed(x));
            k_ext = W_ACC'($signed(k));
        end else begin
            x_ext = W_ACC'(x);
            k_ext = W_ACC'(k);
        end
        prod  = x_ext * k_ext;
        sum_c = (clear ? '0 : acc) + prod;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum_c;
        end
    end

endmodule

// File: rtl/mvm_stream_engine.sv
// Byte-stream matrix-vector multiply engine: persistent K, Y = K*X, serial MAC.
// Define MVM_SATURATE_EN to clamp Y to the output range instead of wrapping.
module mvm_stream_engine
    import mvm_pkg::*;
#(
    parameter int unsigned R       = 2,
    parameter int unsigned C       = 2,
    parameter int unsigned W_X     = 4,
    parameter int unsigned W_K     = 4,
    parameter int unsigned W_Y_OUT = 8,
    parameter bit          SIGNED  = 1'b1
) (
    input logic                clk,
    input logic                rst,
    mvm_stream_engine_if.slave bus
);

    localparam int unsigned W_ACC  = acc_width(W_X, W_K, C);
    localparam int unsigned NB     = bytes_per_y(W_Y_OUT);
    localparam int unsigned N_K    = R * C;
    localparam int unsigned W_KI   = idx_width(N_K);
    localparam int unsigned W_CI   = idx_width(C);
    localparam int unsigned W_RI   = idx_width(R);
    localparam int unsigned W_BI   = idx_width(NB);
    localparam int unsigned W_SER  = NB * 8;
    localparam int unsigned W_WIDE = ((W_ACC > W_Y_OUT) ? W_ACC : W_Y_OUT) + 1;

`ifdef MVM_SATURATE_EN
    localparam logic [W_WIDE-1:0] Y_MAX = SIGNED ?
        ((W_WIDE'(1) << (W_Y_OUT - 1)) - W_WIDE'(1)) :
        ((W_WIDE'(1) << W_Y_OUT) - W_WIDE'(1));
    localparam logic [W_WIDE-1:0] Y_MIN = SIGNED ? ~Y_MAX : '0;
`endif

    state_t             state;
    logic [W_KI-1:0]    load_idx;
    logic [W_CI-1:0]    col;
    logic [W_RI-1:0]    row;
    logic [W_RI-1:0]    out_row;
    logic [W_BI-1:0]    out_byte;
    logic               out_last;

    logic [W_K-1:0]     k_mem [N_K];
    logic [W_X-1:0]     x_mem [C];
    logic [W_Y_OUT-1:0] y_mem [R];

    logic               s_xfer;
    logic               mac_clear;
    logic               mac_en;
    logic [W_ACC-1:0]   sum_c;
    logic [W_WIDE-1:0]  acc_ext;
    logic [W_Y_OUT-1:0] y_red;
    logic [W_SER-1:0]   y_ext;
    logic [7:0]         ser_byte;
    logic               ser_is_last;

    assign s_xfer    = bus.s_valid & bus.s_ready;
    assign mac_clear = (col == '0);
    assign mac_en    = (state == ST_COMPUTE);

    mvm_mac #(
        .W_X    (W_X),
        .W_K    (W_K),
        .W_ACC  (W_ACC),
        .SIGNED (SIGNED)
    ) u_mac (
        .clk   (clk),
        .rst   (rst),
        .clear (mac_clear),
        .en    (mac_en),
        .x     (x_mem[col]),
        .k     (k_mem[load_idx]),
        .sum_c (sum_c)
    );

    // Reduce the finished row sum to W_Y_OUT bits.
    always_comb begin
        if (SIGNED) begin
            acc_ext = W_WIDE'($signed(sum_c));
        end else begin
            acc_ext = W_WIDE'(sum_c);
        end
`ifdef MVM_SATURATE_EN
        if ($signed(acc_ext) > $signed(Y_MAX)) begin
            y_red = W_Y_OUT'(Y_MAX);
        end else if ($signed(acc_ext) < $signed(Y_MIN)) begin
            y_red = W_Y_OUT'(Y_MIN);
        end else begin
            y_red = W_Y_OUT'(acc_ext);
        end
`else
        y_red = W_Y_OUT'(acc_ext);
`endif
    end

    // Little-endian byte of the Y element at the serialiser pointer.
    always_comb begin
        if (SIGNED) begin
            y_ext = W_SER'($signed(y_mem[out_row]));
        end else begin
            y_ext = W_SER'(y_mem[out_row]);
        end
        ser_byte    = y_ext[{out_byte, 3'b000} +: 8];
        ser_is_last = (out_row == W_RI'(R - 1)) && (out_byte == W_BI'(NB - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            load_idx     <= '0;
            col          <= '0;
            row          <= '0;
            out_row      <= '0;
            out_byte     <= '0;
            out_last     <= 1'b0;
            bus.s_ready  <= 1'b1;
            bus.m_valid  <= 1'b0;
            bus.m_data   <= '0;
            bus.k_loaded <= 1'b0;
            bus.busy     <= 1'b0;
            bus.err      <= 1'b0;
            for (int i = 0; i < int'(N_K); i++) k_mem[i] <= '0;
            for (int i = 0; i < int'(C); i++)   x_mem[i] <= '0;
            for (int i = 0; i < int'(R); i++)   y_mem[i] <= '0;
        end else begin
            bus.err <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (s_xfer) begin
                        load_idx <= '0;
                        if (bus.s_data == OP_LOAD_K) begin
                            state        <= ST_LOAD_K;
                            bus.k_loaded <= 1'b0;
                        end else if (bus.s_data == OP_LOAD_X && bus.k_loaded) begin
                            state <= ST_LOAD_X;
                        end else begin
                            bus.err <= 1'b1;
                        end
                    end
                end
                ST_LOAD_K: begin
                    if (s_xfer) begin
                        k_mem[load_idx] <= bus.s_data[W_K-1:0];
                        if (load_idx == W_KI'(N_K - 1)) begin
                            state        <= ST_IDLE;
                            bus.k_loaded <= 1'b1;
                        end else begin
                            load_idx <= load_idx + W_KI'(1);
                        end
                    end
                end
                ST_LOAD_X: begin
                    if (s_xfer) begin
                        x_mem[W_CI'(load_idx)] <= bus.s_data[W_X-1:0];
                        if (load_idx == W_KI'(C - 1)) begin
                            state       <= ST_COMPUTE;
                            bus.s_ready <= 1'b0;
                            bus.busy    <= 1'b1;
                            load_idx    <= '0;
                            row         <= '0;
                            col         <= '0;
                        end else begin
                            load_idx <= load_idx + W_KI'(1);
                        end
                    end
                end
                // load_idx walks K row-major while row/col track the dot product.
                ST_COMPUTE: begin
                    load_idx <= load_idx + W_KI'(1);
                    if (col == W_CI'(C - 1)) begin
                        y_mem[row] <= y_red;
                        col        <= '0;
                        if (row == W_RI'(R - 1)) begin
                            state    <= ST_SEND;
                            out_row  <= '0;
                            out_byte <= '0;
                            out_last <= 1'b0;
                        end else begin
                            row <= row + W_RI'(1);
                        end
                    end else begin
                        col <= col + W_CI'(1);
                    end
                end
                ST_SEND: begin
                    if (!bus.m_valid || bus.m_ready) begin
                        if (bus.m_valid && out_last) begin
                            state       <= ST_IDLE;
                            bus.m_valid <= 1'b0;
                            bus.s_ready <= 1'b1;
                            bus.busy    <= 1'b0;
                            out_last    <= 1'b0;
                        end else begin
                            bus.m_valid <= 1'b1;
                            bus.m_data  <= ser_byte;
                            out_last    <= ser_is_last;
                            if (!ser_is_last) begin
                                if (out_byte == W_BI'(NB - 1)) begin
                                    out_byte <= '0;
                                    out_row  <= out_row + W_RI'(1);
                                end else begin
                                    out_byte <= out_byte + W_BI'(1);
                                end
                            end
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mvm_stream_engine.md
# mvm_stream_engine

Parametrised matrix-vector multiply engine for the UART MVM system. It consumes a byte stream from the UART receiver, holds an R×C weight matrix K across frames, and for each input vector X computes Y = K·X with a serial MAC. It returns Y as bytes to the UART transmitter. It generalises the fixed 2×2, 4-bit, unsigned-only datapath to configurable dimensions, widths, signedness, persistent weights, and optional output saturation.

## Interface
- R, 2, rows of K and length of Y
- C, 2, columns of K and length of X
- W_X, 4, X element width (1..8)
- W_K, 4, K element width (1..8)
- W_Y_OUT, 8, output element width (1..16)
- SIGNED, 1, 1 = two's-complement operands/results, 0 = unsigned
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- s_data  in  8  byte from UART RX
- s_valid  in  1  s_data valid
- s_ready  out  1  engine accepts byte (transfer = s_valid & s_ready)
- m_data  out  8  byte to UART TX
- m_valid  out  1  m_data valid
- m_ready  in  1  TX accepts byte (transfer = m_valid & m_ready)
- k_loaded  out  1  a complete K is held
- busy  out  1  state is COMPUTE or SEND
- err  out  1  one-cycle pulse on protocol error

## Operation
- Frame = header byte + payload. Header 0x01 = LOAD_K: R*C bytes follow, row-major. Header 0x02 = LOAD_X: C bytes follow, then compute and send.
- Each element uses the low W_X/W_K bits of its byte. If SIGNED, those bits are sign-extended; otherwise zero-extended.
- States:
  - IDLE: header -> LOAD_K / LOAD_X / stay with err.
  - LOAD_K: R*C bytes -> IDLE, k_loaded=1.
  - LOAD_X: C bytes -> COMPUTE.
  - COMPUTE: R*C MAC cycles -> SEND.
  - SEND: R*NB bytes -> IDLE.
- Unknown header: err pulse, byte dropped, stay IDLE.
- Header 0x02 while k_loaded=0: err pulse, byte dropped, stay IDLE.
- A partial LOAD_K clears k_loaded at the header. k_loaded is set only when the last K byte is accepted.
- K persists over any number of LOAD_X frames until a new LOAD_K or reset.
- Accumulator width W_ACC = W_X + W_K + clog2(C); sums are exact at this width.
- Y output reduction: with saturation, clamp to the W_Y_OUT range (see Configuration); without it, truncate to the low W_Y_OUT bits.
- NB = ceil(W_Y_OUT/8) bytes per Y element, little-endian, rows in order 0..R-1. Unused top bits of the last byte are sign-extended (SIGNED) or zero.

## Timing
- Reset values:
  - State IDLE.
  - s_ready=1, m_valid=0, m_data=0, k_loaded=0, busy=0, err=0.
  - K, X and Y buffers cleared.
- s_ready=1 in IDLE, LOAD_K, LOAD_X; 0 in COMPUTE and SEND. It is registered and changes the cycle after a state transition.
- COMPUTE starts the cycle after the last X byte is accepted. One MAC per cycle, index (row, col) with col fastest. The accumulator clears at col 0 and is written to the Y buffer at col C-1.
- m_valid rises exactly R*C+1 cycles after the last X byte transfer.
- m_data/m_valid are held stable while m_ready=0. The next byte is presented the cycle after a transfer, giving back-to-back bytes when m_ready stays high.
- After the final byte transfer: IDLE, s_ready=1 on the next cycle.
- err is asserted the cycle after the offending header transfer, for one cycle.
- rst mid-frame, mid-COMPUTE or mid-SEND: all outputs take reset values on the next cycle. The pending Y is discarded and K must be reloaded.

## Configuration
- MVM_SATURATE_EN defined: Y is clamped before serialisation.
  - SIGNED=1: clamp to [-2^(W_Y_OUT-1), 2^(W_Y_OUT-1)-1].
  - SIGNED=0: clamp to [0, 2^W_Y_OUT-1].
- MVM_SATURATE_EN undefined: Y = low W_Y_OUT bits of the accumulator (wrap-around). No clamp logic is instantiated.

## Structure
- Package mvm_pkg holds:
  - State enum.
  - Header opcodes OP_LOAD_K=0x01, OP_LOAD_X=0x02.
  - Functions for W_ACC and NB.
- Sub-module mvm_mac contains the single multiply-accumulate:
  - Operand extension per SIGNED.
  - clear/enable inputs.
  - W_ACC accumulator.
- Top holds the FSM, index counters, K/X/Y register arrays, saturation/truncation and the byte serialiser.

## Test plan
- Basic multiply (R=C=2, W=4, SIGNED=1, W_Y_OUT=8): send 01 01 02 03 04, then 02 05 06 -> m_data 0x11, 0x27; k_loaded=1 after the 5th byte.
- Saturation: K all 0x08 (-8), X 0x08 0x08 -> Y=128 each. Output 0x7F,0x7F with MVM_SATURATE_EN defined; 0x80,0x80 without it.
- Backpressure: hold m_ready=0 for 10 cycles during SEND -> m_valid stays high, m_data stable, s_ready=0. Release -> 0x11, 0x27 in consecutive cycles.
- Protocol errors: header 0x55 -> one-cycle err, no output. Header 0x02 right after reset -> err, no output. A following valid 0x01 frame is accepted normally.
- Weight reuse: one LOAD_K, then X=(1,0) and X=(0,1) -> outputs 0x01,0x03 then 0x02,0x04. Check that m_valid rises 5 cycles after each last X byte.
- Reset mid-COMPUTE: assert rst for one cycle 2 cycles into COMPUTE -> no m_valid, k_loaded=0, s_ready=1. A subsequent 02 frame gives err.
